// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter onto one UART TX byte channel
//
// Purpose:
//   Shares a single UART transmitter byte channel among NUM_REQ byte sources.
//   The grant is held for a whole packet, up to and including the byte marked
//   req_last. An optional header byte (HDR_BASE | grant_id) can precede each
//   packet. A watchdog drops the grant if the owner stops offering bytes
//   mid-packet.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous reset, active-low
//   req_valid    in   [NUM_REQ]    per-requester byte valid
//   req_data     in   [8*NUM_REQ]  per-requester byte, requester i on [8i+7:8i]
//   req_last     in   [NUM_REQ]    final byte of the requester's packet
//   req_ready    out  [NUM_REQ]    per-requester byte accepted
//   tx_valid     out  byte valid to the transmitter
//   tx_data      out  [8] byte to the transmitter
//   tx_ready     in   transmitter can accept a byte
//   grant        out  [NUM_REQ]    one-hot owner, zero when idle
//   grant_id     out  [ID_W]       binary index of the owner
//   busy         out  high while a packet (header or data) is in flight
//   timeout_flag out  one-cycle pulse when the watchdog releases the grant

module uart_tx_arbiter #(
  parameter int         NUM_REQ  = 4,
  parameter bit         HDR_EN   = 1'b1,
  parameter logic [7:0] HDR_BASE = 8'hA0,
  parameter int         TIMEOUT  = 62500,
  localparam int        ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic                busy_q, busy_d;
  logic                timeout_flag_q, timeout_flag_d;
  logic [15:0]         timer_q, timer_d;

  // Round-robin pick
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     pick_id;
  logic                pick_found;

  // View of the granted requester
  logic                g_valid;
  logic                g_last;
  logic [7:0]          g_data;
  logic [7:0]          hdr_byte;
  logic                xfer;

  assign g_valid  = req_valid[grant_id_q];
  assign g_last   = req_last[grant_id_q];
  assign g_data   = req_data[{grant_id_q, 3'b000} +: 8];
  assign hdr_byte = HDR_BASE | {{(8-ID_W){1'b0}}, grant_id_q};
  assign xfer     = tx_valid && tx_ready;

  // Scan starts one past the previous owner so every requester gets a turn
  // before anyone is served twice.
  always_comb begin
    cand       = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_q) + 1 + i) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      grant_q        <= '0;
      grant_id_q     <= '0;
      last_grant_q   <= ID_W'(NUM_REQ - 1);
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      busy_q         <= busy_d;
      timeout_flag_q <= timeout_flag_d;
      timer_q        <= timer_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    timeout_flag_d = 1'b0;
    timer_d        = timer_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pick_found) begin
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          grant_id_d       = pick_id;
          state_d          = HDR_EN ? S_HDR : S_DATA;
        end
      end

      S_HDR: begin
        // Header is always valid, so tx_ready alone completes it.
        if (tx_ready) begin
          state_d = S_DATA;
          timer_d = '0;
        end
      end

      S_DATA: begin
        if (xfer) begin
          // A transfer always wins over an expiring watchdog.
          timer_d = '0;
          if (g_last) begin
            state_d      = S_IDLE;
            last_grant_d = grant_id_q;
            grant_d      = '0;
          end
        end else if (!g_valid) begin
          // Only an absent byte counts as a stall; back-pressure holds the timer.
          if (timer_q == TIMER_LIMIT) begin
            state_d        = S_IDLE;
            last_grant_d   = grant_id_q;
            grant_d        = '0;
            timeout_flag_d = 1'b1;
            timer_d        = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Output logic: the data phase is a combinational passthrough of the owner.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
      end
      S_DATA: begin
        tx_valid              = g_valid;
        tx_data               = g_data;
        req_ready[grant_id_q] = tx_ready;
      end
      default: begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
      end
    endcase
  end

  assign grant        = grant_q;
  assign grant_id     = grant_id_q;
  assign busy         = busy_q;
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_flag;

  uart_tx_arbiter #(
    .NUM_REQ  (4),
    .HDR_EN   (1'b1),
    .HDR_BASE (8'hA0),
    .TIMEOUT  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .grant        (grant),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;
  int cyc;

  // Per-requester byte sources: {last, data}
  logic [8:0]  src_mem [4][8];
  int          src_len [4];
  int          src_pos [4];

  logic [7:0]  tx_log  [$];
  int          tx_cyc  [$];
  logic [7:0]  exp_log [$];

  logic        s_busy, s_txv, s_tf;
  logic [3:0]  s_grant, s_rr;
  logic [1:0]  s_gid;
  logic [7:0]  s_txd;
  logic        stable_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic last);
    src_mem[r][src_len[r]] = {last, b};
    src_len[r]++;
  endtask

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = src_mem[i][src_pos[i]][7:0];
        req_last[i]         = src_mem[i][src_pos[i]][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // Called at a falling edge: drive sources, sample, then advance to the next falling edge.
  task automatic run_cycle();
    drive_src();
    #1;
    s_busy  = busy;
    s_txv   = tx_valid;
    s_txd   = tx_data;
    s_tf    = timeout_flag;
    s_grant = grant;
    s_gid   = grant_id;
    s_rr    = req_ready;
    if (tx_valid && tx_ready) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) src_pos[i]++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_test();
    tx_log.delete();
    tx_cyc.delete();
    cyc = 0;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 32'(tx_log.size()), 32'(exp_log.size()));
    for (int k = 0; k < exp_log.size() && k < tx_log.size(); k++)
      check($sformatf("%s_b%0d", tag, k), 32'(tx_log[k]), 32'(exp_log[k]));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_src();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    clk       = 1'b0;
    reset     = 1'b0;
    tx_ready  = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_src();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_grant",    32'(grant),        32'h0);
    check("rst_grant_id", 32'(grant_id),     32'h0);
    check("rst_busy",     32'(busy),         32'h0);
    check("rst_tx_valid", 32'(tx_valid),     32'h0);
    check("rst_tx_data",  32'(tx_data),      32'h0);
    check("rst_req_ready",32'(req_ready),    32'h0);
    check("rst_tflag",    32'(timeout_flag), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // 1: single packet from requester 1
    start_test();
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b1);
    run_cycle();
    check("t1_idle_busy", 32'(s_busy), 32'h0);
    check("t1_idle_txv",  32'(s_txv),  32'h0);
    run_cycle();
    check("t1_hdr_grant", 32'(s_grant), 32'h2);
    check("t1_hdr_gid",   32'(s_gid),   32'h1);
    check("t1_hdr_busy",  32'(s_busy),  32'h1);
    check("t1_hdr_data",  32'(s_txd),   32'hA1);
    check("t1_hdr_rr",    32'(s_rr),    32'h0);
    run_cycle();
    check("t1_d0_rr",     32'(s_rr),    32'h2);
    check("t1_d0_data",   32'(s_txd),   32'h11);
    run_cycle();
    check("t1_d1_busy",   32'(s_busy),  32'h1);
    check("t1_d1_data",   32'(s_txd),   32'h22);
    run_cycle();
    check("t1_end_busy",  32'(s_busy),  32'h0);
    check("t1_end_grant", 32'(s_grant), 32'h0);
    exp_log = '{8'hA1, 8'h11, 8'h22};
    check_log("t1_log");

    // 2: four single-byte packets after reset, served 0..3
    apply_reset();
    start_test();
    for (int i = 0; i < 4; i++) push(i, 8'(8'h50 + i), 1'b1);
    repeat (14) run_cycle();
    exp_log = '{8'hA0, 8'h50, 8'hA1, 8'h51, 8'hA2, 8'h52, 8'hA3, 8'h53};
    check_log("t2_log");
    if (tx_cyc.size() == 8) begin
      check("t2_cyc_hdr1", 32'(tx_cyc[2]), 32'd4);
      check("t2_cyc_last", 32'(tx_cyc[7]), 32'd11);
    end else begin
      check("t2_cyc_count", 32'(tx_cyc.size()), 32'd8);
    end

    // 3: packet lock while requester 2 waits
    start_test();
    push(0, 8'h01, 1'b0);
    push(0, 8'h02, 1'b0);
    push(0, 8'h03, 1'b1);
    run_cycle();
    run_cycle();
    run_cycle();
    push(2, 8'hAA, 1'b1);
    run_cycle();
    check("t3_c3_rr",    32'(s_rr),    32'h1);
    check("t3_c3_grant", 32'(s_grant), 32'h1);
    check("t3_c3_data",  32'(s_txd),   32'h02);
    run_cycle();
    check("t3_c4_rr",    32'(s_rr),    32'h1);
    run_cycle();
    check("t3_c5_busy",  32'(s_busy),  32'h0);
    run_cycle();
    check("t3_c6_grant", 32'(s_grant), 32'h4);
    check("t3_c6_rr",    32'(s_rr),    32'h0);
    run_cycle();
    check("t3_c7_rr",    32'(s_rr),    32'h4);
    run_cycle();
    exp_log = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'hA2, 8'hAA};
    check_log("t3_log");

    // 4: watchdog release, requester 0 pending
    start_test();
    push(3, 8'h7E, 1'b0);
    push(0, 8'hC0, 1'b1);
    run_cycle();
    run_cycle();
    check("t4_hdr_gid", 32'(s_gid), 32'h3);
    run_cycle();
    repeat (15) run_cycle();
    run_cycle();
    check("t4_c18_tf",    32'(s_tf),    32'h0);
    check("t4_c18_busy",  32'(s_busy),  32'h1);
    check("t4_c18_grant", 32'(s_grant), 32'h8);
    run_cycle();
    check("t4_c19_tf",    32'(s_tf),    32'h1);
    check("t4_c19_busy",  32'(s_busy),  32'h0);
    check("t4_c19_grant", 32'(s_grant), 32'h0);
    check("t4_c19_txv",   32'(s_txv),   32'h0);
    run_cycle();
    check("t4_c20_tf",    32'(s_tf),    32'h0);
    check("t4_c20_grant", 32'(s_grant), 32'h1);
    check("t4_c20_data",  32'(s_txd),   32'hA0);
    run_cycle();
    run_cycle();
    check("t4_c22_busy",  32'(s_busy),  32'h0);
    exp_log = '{8'hA3, 8'h7E, 8'hA0, 8'hC0};
    check_log("t4_log");

    // 5: 40 cycles of back-pressure in the data phase never time out
    start_test();
    push(0, 8'h5A, 1'b1);
    run_cycle();
    run_cycle();
    tx_ready  = 1'b0;
    stable_ok = 1'b1;
    repeat (40) begin
      run_cycle();
      if (s_txv !== 1'b1 || s_txd !== 8'h5A || s_tf !== 1'b0 || s_busy !== 1'b1)
        stable_ok = 1'b0;
    end
    check("t5_stable", 32'(stable_ok), 32'h1);
    tx_ready = 1'b1;
    run_cycle();
    run_cycle();
    check("t5_end_busy", 32'(s_busy), 32'h0);
    check("t5_end_tf",   32'(s_tf),   32'h0);
    exp_log = '{8'hA0, 8'h5A};
    check_log("t5_log");

    // 6: asynchronous reset in the middle of a data byte
    start_test();
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b1);
    run_cycle();
    run_cycle();
    run_cycle();
    drive_src();
    #1;
    check("t6_pre_txv", 32'(tx_valid), 32'h1);
    reset = 1'b0;
    #1;
    check("t6_rst_txv",   32'(tx_valid),  32'h0);
    check("t6_rst_grant", 32'(grant),     32'h0);
    check("t6_rst_rr",    32'(req_ready), 32'h0);
    check("t6_rst_busy",  32'(busy),      32'h0);
    @(negedge clk);
    reset = 1'b1;
    clear_src();
    start_test();
    push(0, 8'hE0, 1'b1);
    push(2, 8'hE2, 1'b1);
    run_cycle();
    run_cycle();
    check("t6_post_grant", 32'(s_grant), 32'h1);
    check("t6_post_data",  32'(s_txd),   32'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter byte channel among NUM_REQ requesters.
- Arbitration is round-robin at packet granularity. A grant is held until the requester's last byte has been accepted.
- Each packet can optionally be prefixed with a header byte that carries the requester ID.
- A starvation watchdog releases the grant if the granted requester stalls mid-packet.
- Sits between on-chip byte sources (MCU core, debug, status) and the UART TX serializer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HDR_EN, 1, 1 = send header byte before each packet; 0 = no header
HDR_BASE, 8'hA0, header byte = HDR_BASE | grant_id (ID occupies the low bits)
TIMEOUT, 62500, starvation limit in clk cycles (1.25 ms at 50 MHz); 16-bit counter

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous reset, active-low
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks final byte of a packet
req_ready  out  NUM_REQ  per-requester byte accepted
tx_valid  out  1  byte valid to transmitter
tx_data  out  8  byte to transmitter
tx_ready  in  1  transmitter can accept a byte
grant  out  NUM_REQ  one-hot current owner; all zero when idle
grant_id  out  $clog2(NUM_REQ)  binary index of the owner
busy  out  1  high in HDR and DATA states
timeout_flag  out  1  one-cycle pulse on watchdog release

Behaviour:
- Transfer rule: a transfer occurs on a clock edge where tx_valid && tx_ready.
- Reset (reset=0, asynchronous):
  - state=IDLE; grant=0; grant_id=0; busy=0; tx_valid=0; tx_data=0; req_ready=0; timeout_flag=0; timer=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - No tx_valid, no req_ready.
  - If any req_valid is high, select the first set bit scanning from (last_grant+1) mod NUM_REQ upward, with wrap.
  - Register grant and grant_id; next state is HDR if HDR_EN, else DATA.
  - Arbitration costs exactly one cycle, so there is at least one idle cycle between packets.
- HDR:
  - tx_valid=1; tx_data=HDR_BASE|grant_id, held stable until tx_ready.
  - On transfer, go to DATA.
  - req_ready=0 in this state.
- DATA (combinational passthrough for the granted index g):
  - tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready.
  - All other req_ready bits are 0.
  - On a transfer with req_last[g]=1: go to IDLE, set last_grant=g, clear grant.
- Watchdog (DATA only):
  - Timer clears on every transfer and on entry to DATA.
  - Increments only while req_valid[g]=0. It holds while req_valid[g]=1 and tx_ready=0, so back-pressure never times out.
  - When the timer reaches TIMEOUT-1 with no transfer: go to IDLE, set last_grant=g, pulse timeout_flag for 1 cycle, clear grant.
  - The remainder of that packet is dropped by the arbiter; the requester is responsible for recovery.
- Simultaneous events:
  - Transfer and timeout in the same cycle: the transfer wins and the timer clears.
  - A last-byte transfer always returns to IDLE, even if other requesters are waiting.
- Other boundaries:
  - The granted requester dropping req_valid before DATA is covered by the watchdog.
  - Non-granted requester signals are ignored and never change the grant mid-packet.
- Registered vs combinational outputs:
  - Registered: grant, grant_id, busy, timeout_flag, state.
  - Combinational in DATA: tx_valid, tx_data, req_ready.
- Reset mid-packet: all outputs return to reset values immediately; any partial packet is abandoned.

Test Plan:
1. Single packet, HDR_EN=1, tx_ready=1. Requester 1 sends 8'h11, then 8'h22 with last.
   -> tx bytes A1, 11, 22. grant=0010 and busy=1 from the cycle after first req_valid until the 22 transfer, then busy=0.
2. All four requesters assert single-byte last packets (8'h50..8'h53) after reset.
   -> Order of service is 0, 1, 2, 3. tx stream is A0 50 A1 51 A2 52 A3 53, with one idle cycle between packets.
3. Packet lock. Requester 0 sends a 3-byte packet (01 02 03) while requester 2 asserts valid after byte 01.
   -> No interleaving; tx stream is A0 01 02 03 A2 xx. req_ready[2]=0 until its grant.
4. Timeout with TIMEOUT=16. Requester 3 sends 8'h7E (not last), then drops valid.
   -> timeout_flag pulses 16 cycles after the 7E transfer; state returns to IDLE. A pending requester 0 is granted next.
5. Back-pressure. tx_ready=0 for 40 cycles with req_valid[0]=1, TIMEOUT=16.
   -> No timeout; tx_data stays stable. The transfer completes when tx_ready rises.
6. Assert reset low for 1 cycle in the middle of a DATA byte.
   -> tx_valid, grant, req_ready and busy are 0 immediately. After release, requester 0 has first priority.
